// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//
// Purpose: groups the byte-stream handshake signals between the requester
//          FIFOs, the arbiter and the shared uart_tx instance.
//
// Signals:
//   req_tdata   N_REQ*8  requester bytes, requester i at [8i+7:8i]
//   req_tvalid  N_REQ    requester byte valid
//   req_tlast   N_REQ    last byte of requester packet
//   req_tready  N_REQ    byte accepted from requester
//   m_axis_*    8/1/1    byte stream towards uart_tx
//   uart_busy   1        uart_tx is shifting a byte out
//
// Modports:
//   master  arbiter side
//   slave   requester FIFOs + uart_tx side
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ*8-1:0] req_tdata;
    logic [N_REQ-1:0]   req_tvalid;
    logic [N_REQ-1:0]   req_tlast;
    logic [N_REQ-1:0]   req_tready;
    logic [7:0]         m_axis_tdata;
    logic               m_axis_tvalid;
    logic               m_axis_tready;
    logic               uart_busy;

    modport master (
        input  req_tdata, req_tvalid, req_tlast, m_axis_tready, uart_busy,
        output req_tready, m_axis_tdata, m_axis_tvalid
    );

    modport slave (
        output req_tdata, req_tvalid, req_tlast, m_axis_tready, uart_busy,
        input  req_tready, m_axis_tdata, m_axis_tvalid
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose: shares one uart_tx byte transmitter between N_REQ byte-stream
//          requesters. The transmitter is granted packet-by-packet in
//          round-robin order, with at most MAX_BYTES bytes per grant before a
//          forced release. The arbiter also owns the uart_tx prescale value
//          and only changes it while the line is idle.
//
// Ports:
//   clk           in   clock
//   rst_n         in   asynchronous active-low reset
//   bus           if   handshake bundle (uart_tx_arbiter_if.master)
//   prescale      out  prescale value driven to uart_tx
//   cfg_prescale  in   new prescale value
//   cfg_update    in   one-cycle pulse, latch cfg_prescale as pending
//   cfg_pending   out  an update is latched but not yet applied
//   grant_id      out  current owner
//   active        out  a grant is held
//
// Build option:
//   UART_TX_ARB_PRIO_EN  when defined, requester 0 wins every IDLE
//                        arbitration it takes part in (no preemption of a
//                        held grant); otherwise pure round-robin.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int                    N_REQ        = 4,
    parameter int                    MAX_BYTES    = 16,
    parameter int                    PRESCALE_W   = 16,
    parameter logic [PRESCALE_W-1:0] PRESCALE_RST = PRESCALE_W'(1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    uart_tx_arbiter_if.master          bus,
    output logic [PRESCALE_W-1:0]      prescale,
    input  logic [PRESCALE_W-1:0]      cfg_prescale,
    input  logic                       cfg_update,
    output logic                       cfg_pending,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       active
);

    localparam int IDW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    logic [IDW-1:0]        r_grant_id;
    logic [IDW-1:0]        r_rr_ptr;
    logic                  r_active;
    logic [7:0]            r_byte_cnt;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [PRESCALE_W-1:0] r_pending_val;
    logic                  r_cfg_pending;

    logic                  w_busy;
    logic [IDW-1:0]        w_winner;
    logic                  w_grant;
    logic                  w_hs;
    logic                  w_release;
    logic                  w_apply;
    logic [IDW-1:0]        w_next_ptr;

    assign w_busy = bus.uart_busy;

    // Round-robin search starting at r_rr_ptr, wrapping at N_REQ-1 -> 0.
    // The index is kept one bit wider so the wrap works for any N_REQ,
    // including non-powers of two.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin : arbitrate
        logic [IDW:0] idx;
        logic         found;
        w_winner = '0;
        found    = 1'b0;
        idx      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, r_rr_ptr} + (IDW+1)'(i);
            if (idx >= (IDW+1)'(N_REQ)) begin
                idx = idx - (IDW+1)'(N_REQ);
            end
            if (!found && bus.req_tvalid[idx[IDW-1:0]]) begin
                found    = 1'b1;
                w_winner = idx[IDW-1:0];
            end
        end
`ifdef UART_TX_ARB_PRIO_EN
        // Requester 0 overrides the round-robin pick, but only here in IDLE.
        if (bus.req_tvalid[0]) begin
            w_winner = '0;
        end
`else
`endif
    end

    assign w_grant = (r_state == IDLE) && (|bus.req_tvalid) && !w_busy;

    // Stream outputs are combinational in XFER so a byte can pass in the same
    // cycle the requester presents it; all zero outside XFER.
    always_comb begin : stream_mux
        bus.m_axis_tvalid = 1'b0;
        bus.m_axis_tdata  = 8'h00;
        bus.req_tready    = '0;
        if (r_state == XFER) begin
            bus.m_axis_tvalid          = bus.req_tvalid[r_grant_id] && !w_busy;
            bus.m_axis_tdata           = bus.req_tdata[{r_grant_id, 3'b000} +: 8];
            bus.req_tready[r_grant_id] = bus.m_axis_tready && !w_busy;
        end
    end

    assign w_hs = bus.m_axis_tvalid && bus.m_axis_tready;

    // Release on end of packet or when this handshake is the MAX_BYTES-th of
    // the grant (forced release; the requester continues on a later grant).
    assign w_release = bus.req_tlast[r_grant_id] ||
                       (r_byte_cnt == 8'(MAX_BYTES - 1));

    assign w_next_ptr = (r_grant_id == IDW'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    // NOTE: every flop, including the pending prescale value, is cleared by
    // rst_n so the block restarts from a known state after a mid-packet
    // reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_active   <= 1'b0;
            r_byte_cnt <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_grant_id <= w_winner;
                        r_active   <= 1'b1;
                        r_byte_cnt <= 8'd0;
                        r_state    <= XFER;
                    end
                end
                XFER: begin
                    // A stalled owner (tvalid low, no tlast) keeps the grant.
                    if (w_hs) begin
                        r_byte_cnt <= r_byte_cnt + 8'd1;
                        if (w_release) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Wait for uart_tx to finish the last byte before rearbitrating.
                    if (!w_busy && bus.m_axis_tready) begin
                        r_rr_ptr <= w_next_ptr;
                        r_active <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Apply only on an idle line with no grant being issued; a grant in the
    // same cycle wins and the apply waits for the next idle cycle.
    assign w_apply = (r_state == IDLE) && !w_busy && !w_grant && r_cfg_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescale    <= PRESCALE_RST;
            r_pending_val <= PRESCALE_RST;
            r_cfg_pending <= 1'b0;
        end else begin
            if (w_apply) begin
                r_prescale    <= r_pending_val;
                r_cfg_pending <= 1'b0;
            end
            // A fresh update overrides the clear above: the new value stays
            // pending even if the previous one was applied this cycle.
            if (cfg_update) begin
                r_pending_val <= cfg_prescale;
                r_cfg_pending <= 1'b1;
            end
        end
    end

    assign prescale    = r_prescale;
    assign cfg_pending = r_cfg_pending;
    assign grant_id    = r_grant_id;
    assign active      = r_active;

endmodule
